// File: rtl/mem_responder.sv
// Purpose: services datapath fetch/data requests on a single-port RAM in place of a cache.
// Latency: hit pulse one cycle after the RAM reports ACCESS; minimum is a hit two cycles after the request is sampled.
// Backpressure: requests are level-held and wait in IDLE; a stalled RAM is cut off after TIMEOUT cycles.
module mem_responder #(
    parameter int          TIMEOUT  = 64,
    parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic [31:0] imemload,
    output logic        ihit,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic [31:0] dmemload,
    output logic        dhit,
    input  logic        halt,
    output logic        flushed,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        memerr
);
    localparam int         CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic [2:0] {IDLE, DACC, IACC, DONE, HALTED} state_t;

    state_t            state, state_nxt;
    logic [31:0]       addr_q, store_q;
    logic              write_q, data_q;
    logic [CNT_W-1:0]  cnt;
    logic              in_acc, acc_ok, acc_fail;
    logic              take_d, take_i;

    assign in_acc   = (state == DACC) || (state == IACC);
    assign acc_ok   = (ramstate == RS_ACCESS);
    assign acc_fail = !acc_ok && ((ramstate == RS_ERROR) || (cnt == CNT_W'(TIMEOUT - 1)));
    assign ramaddr  = addr_q;
    assign ramstore = store_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        take_d    = 1'b0;
        take_i    = 1'b0;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ihit      = 1'b0;
        dhit      = 1'b0;
        flushed   = 1'b0;
        case (state)
            IDLE: begin
                // Halt wins over any pending request; data beats fetch.
                if (halt) begin
                    state_nxt = HALTED;
                end else if (dmemREN || dmemWEN) begin
                    take_d    = 1'b1;
                    state_nxt = DACC;
                end else if (imemREN) begin
                    take_i    = 1'b1;
                    state_nxt = IACC;
                end
            end
            DACC: begin
                ramWEN = write_q;
                ramREN = !write_q;
                if (acc_ok || acc_fail) state_nxt = DONE;
            end
            IACC: begin
                ramREN = 1'b1;
                if (acc_ok || acc_fail) state_nxt = DONE;
            end
            DONE: begin
                dhit      = data_q;
                ihit      = !data_q;
                state_nxt = IDLE;
            end
            HALTED: begin
                flushed = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            addr_q   <= '0;
            store_q  <= '0;
            write_q  <= 1'b0;
            data_q   <= 1'b0;
            cnt      <= '0;
            imemload <= '0;
            dmemload <= '0;
            memerr   <= 1'b0;
        end else begin
            if (take_d) begin
                addr_q  <= dmemaddr;
                store_q <= dmemstore;
                write_q <= dmemWEN;
                data_q  <= 1'b1;
                cnt     <= '0;
            end else if (take_i) begin
                addr_q  <= imemaddr;
                write_q <= 1'b0;
                data_q  <= 1'b0;
                cnt     <= '0;
            end
            if (in_acc) begin
                cnt <= cnt + CNT_W'(1);
                // Writes never touch dmemload, even on a fault.
                if (acc_ok) begin
                    if (data_q && !write_q) dmemload <= ramload;
                    else if (!data_q)       imemload <= ramload;
                end else if (acc_fail) begin
                    memerr <= 1'b1;
                    if (data_q && !write_q) dmemload <= ERR_WORD;
                    else if (!data_q)       imemload <= ERR_WORD;
                end
            end
        end
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder end of the datapath-to-cache request protocol.
- Accepts level-held instruction-fetch and data read/write requests from the datapath, arbitrates them onto a single-port RAM, and returns data with one-cycle ihit/dhit pulses.
- Sits between the datapath and RAM in place of a cache; it also tracks halt/flush and RAM faults.

Parameters:
TIMEOUT  64  max cycles an access waits for RAM ACCESS before forced completion (>=1)
ERR_WORD  32'hBAD1BAD1  load value returned on fault/timeout

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  async reset, active low
imemREN  in  1  instruction fetch request (level)
imemaddr  in  32  fetch address
imemload  out  32  fetched instruction (registered)
ihit  out  1  one-cycle fetch completion pulse
dmemREN  in  1  data read request (level)
dmemWEN  in  1  data write request (level)
dmemaddr  in  32  data address
dmemstore  in  32  write data
dmemload  out  32  read data (registered)
dhit  out  1  one-cycle data completion pulse
halt  in  1  datapath halted
flushed  out  1  all traffic drained after halt
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
memerr  out  1  sticky fault flag

Behaviour:
- Reset (async, nRST low): state IDLE; all outputs 0, including imemload, dmemload, ihit, dhit, flushed, memerr, ram strobes, ramaddr and ramstore. Reset mid-access drops the RAM strobes immediately; no hit is issued.
- States: IDLE, DACC, IACC, DONE, HALTED.
- IDLE arbitration (one decision per cycle):
  - halt=1 -> HALTED.
  - Else dmemREN|dmemWEN -> latch dmemaddr, dmemstore and write=dmemWEN, then DACC. Data has priority over fetch. If both REN and WEN are high, the access is a write.
  - Else imemREN -> latch imemaddr, then IACC.
  - Else stay in IDLE.
- DACC/IACC:
  - ramaddr and ramstore come from the latched registers. Latched values are used even if the requester changes its inputs mid-access.
  - DACC drives ramWEN=write and ramREN=!write. IACC drives ramREN=1 and ramWEN=0.
  - Wait counter starts at 0 on entry and increments each cycle in the state.
- Completion:
  - First cycle with ramstate==ACCESS: capture ramload into dmemload (DACC read) or imemload (IACC) at the clock edge. A write leaves dmemload unchanged. Go to DONE.
  - ramstate==ERROR, or counter==TIMEOUT-1 without ACCESS: load ERR_WORD into the target register (reads only), set memerr, go to DONE.
- DONE (exactly one cycle):
  - RAM strobes are 0.
  - Exactly one of dhit/ihit is 1, matching the completed access.
  - No arbitration happens; the requester deasserts or changes its request during this cycle.
  - Next state: IDLE.
- Latency: the request is sampled in IDLE at cycle 0; the RAM strobe is high from cycle 1. If ACCESS occurs in cycle k (k>=1), the hit is high in cycle k+1. With a zero-wait RAM the minimum is hit at cycle 2.
- Halt:
  - If halt rises during DACC/IACC/DONE, the access completes normally and HALTED is entered from the next IDLE.
  - HALTED: flushed=1, strobes 0, all requests ignored, no hits. Only reset exits.
- memerr: set on fault/timeout, cleared only by reset.
- Counter width: $clog2(TIMEOUT+1) bits. It must not wrap before TIMEOUT.

Test Plan:
- Zero-wait fetch: ramstate=ACCESS, imemREN=1, imemaddr=0x40, ramload=0x8C220004 -> ramREN=1 and ramaddr=0x40 in cycle 1; ihit=1 and imemload=0x8C220004 in cycle 2; no strobe in cycle 2.
- Data priority: imemREN=dmemREN=1, dmemaddr=0x100, ramload=0xDEADBEEF -> DACC first, dhit with dmemload=0xDEADBEEF; fetch is then served after DONE, ihit two cycles after arbitration.
- Write with wait states: dmemWEN=1, addr 0x200, store 0x12345678; ramstate BUSY for 3 cycles then ACCESS -> ramWEN held 4 cycles with stable addr/data, dhit one cycle later, dmemload unchanged.
- Timeout/error: TIMEOUT=4, ramstate stuck BUSY on a read -> strobe for 4 cycles, then dhit with dmemload=0xBAD1BAD1 and memerr=1 sticky. Repeat with ramstate=ERROR -> same result after 1 cycle.
- Halt: halt=1 raised mid-fetch -> ihit still issued, then flushed=1 and requests ignored. Assert nRST=0 mid-DACC -> strobes drop asynchronously, all outputs 0, no dhit.
